rmii_rx_framer: RTL and testbench

//  Receive front-end for the RMII PHY. Samples raw crsdv/rxd, strips the preamble and SFD,
//  and emits a continuous dibit stream of frame body (MAC dst..FCS inclusive) for eth_parser.

---
 rtl/rmii_rx_framer_pkg.sv | 29 ++
 rtl/rmii_rx_framer_crc32.sv | 35 +++
 rtl/rmii_rx_framer.sv | 163 ++++++++++++++++
 tb/tb_rmii_rx_framer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rmii_rx_framer_pkg.sv
// Shared Ethernet framing constants, FSM state type and the dibit-serial CRC-32 step
// used by the RMII receive path.
package rmii_rx_framer_pkg;

  localparam logic [31:0] ETH_CRC_RESIDUE    = 32'hdebb20e3;
  localparam logic [31:0] ETH_CRC_POLY       = 32'hedb88320;
  localparam int          ETH_MIN_FRAME_LEN  = 64;
  localparam int          ETH_MAX_FRAME_LEN  = 1518;
  localparam logic [1:0]  ETH_SFD_DIBIT      = 2'b11;
  localparam logic [1:0]  ETH_PREAMBLE_DIBIT = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_BODY,
    ST_DROP
  } rx_state_t;

  // Reflected CRC-32, two wire bits per call, d[0] first on the wire.
  function automatic logic [31:0] crc32_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ ETH_CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/rmii_rx_framer_crc32.sv
// Dibit-serial CRC-32 accumulator; out is the complemented register, so a frame that
// includes a correct FCS leaves out == ~ETH_CRC_RESIDUE.
module rmii_rx_framer_crc32
  import rmii_rx_framer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inclk,
  input  logic [1:0]  in,
  input  logic        shift,
  output logic [31:0] out
);

  logic [31:0] crc_reg;
  logic [31:0] crc_next;

  always_comb begin
    crc_next = crc_reg;
    if (inclk) begin
      // shift mode drains the register two bits at a time for serial readout
      crc_next = shift ? {2'b11, crc_reg[31:2]} : crc32_dibit(crc_reg, in);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_reg <= '1;
    end else begin
      crc_reg <= crc_next;
    end
  end

  assign out = ~crc_reg;

endmodule

// File: rtl/rmii_rx_framer.sv
// RMII receive framer: strips preamble/SFD, emits a gap-free body dibit stream one cycle
// after sampling, and flags FCS, runt, oversize and alignment status with done.
module rmii_rx_framer
  import rmii_rx_framer_pkg::*;
#(
  parameter int MIN_FRAME_BYTES = ETH_MIN_FRAME_LEN,
  parameter int MAX_FRAME_BYTES = ETH_MAX_FRAME_LEN,
  parameter int PREAMBLE_MIN    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       crsdv,
  input  logic [1:0] rxd,
  output logic       outclk,
  output logic [1:0] out,
  output logic       done,
  output logic       crc_ok,
  output logic       err
);

  localparam int          PCNT_W     = $clog2(PREAMBLE_MIN + 1);
  localparam logic [13:0] MIN_DIBITS = 14'(MIN_FRAME_BYTES * 4);
  localparam logic [13:0] MAX_DIBITS = 14'(MAX_FRAME_BYTES * 4);

  rx_state_t          state_reg, state_next;
  logic [PCNT_W-1:0]  pcnt_reg, pcnt_next;
  logic [13:0]        dcnt_reg, dcnt_next;
  logic               s_valid_reg, s_valid_next;
  logic               s_crsdv_reg, s_crsdv_next;
  logic [1:0]         s_rxd_reg, s_rxd_next;
  logic               outclk_reg, outclk_next;
  logic [1:0]         out_reg, out_next;
  logic               done_reg, done_next;
  logic               err_reg, err_next;
  logic               crc_chk_reg, crc_chk_next;
  logic               sfd_accept;
  logic               emit;
  logic [31:0]        crc_out;

  // A staged dibit is real data if it or its successor was sampled with CRS_DV high.
  assign emit = s_valid_reg & (s_crsdv_reg | crsdv);

  always_comb begin
    state_next   = state_reg;
    pcnt_next    = pcnt_reg;
    dcnt_next    = dcnt_reg;
    s_valid_next = s_valid_reg;
    s_crsdv_next = s_crsdv_reg;
    s_rxd_next   = s_rxd_reg;
    outclk_next  = 1'b0;
    out_next     = 2'b00;
    done_next    = 1'b0;
    err_next     = 1'b0;
    crc_chk_next = 1'b0;
    sfd_accept   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (crsdv) begin
          state_next = ST_PREAMBLE;
          pcnt_next  = '0;
        end
      end

      ST_PREAMBLE: begin
        if (!crsdv) begin
          state_next = ST_IDLE;
        end else if (rxd == ETH_PREAMBLE_DIBIT) begin
          if (pcnt_reg < PCNT_W'(PREAMBLE_MIN)) begin
            pcnt_next = pcnt_reg + 1'b1;
          end
        end else if (rxd == ETH_SFD_DIBIT) begin
          if (pcnt_reg >= PCNT_W'(PREAMBLE_MIN)) begin
            state_next   = ST_BODY;
            sfd_accept   = 1'b1;
            dcnt_next    = '0;
            s_valid_next = 1'b0;
          end else begin
            state_next = ST_DROP;
          end
        end else if (rxd == 2'b10) begin
          state_next = ST_DROP;
        end
      end

      ST_BODY: begin
        s_valid_next = 1'b1;
        s_crsdv_next = crsdv;
        s_rxd_next   = rxd;
        if (s_valid_reg && !s_crsdv_reg && !crsdv) begin
          // carrier gone for two samples: the staged dibit is idle line, not data
          state_next   = ST_IDLE;
          done_next    = 1'b1;
          crc_chk_next = 1'b1;
          err_next     = (dcnt_reg < MIN_DIBITS) | (dcnt_reg[1:0] != 2'b00);
        end else if (emit) begin
          if (dcnt_reg == MAX_DIBITS) begin
            state_next = ST_DROP;
            done_next  = 1'b1;
            err_next   = 1'b1;
          end else begin
            outclk_next = 1'b1;
            out_next    = s_rxd_reg;
            dcnt_next   = dcnt_reg + 14'd1;
          end
        end
      end

      ST_DROP: begin
        if (!crsdv) begin
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      pcnt_reg    <= '0;
      dcnt_reg    <= '0;
      s_valid_reg <= 1'b0;
      s_crsdv_reg <= 1'b0;
      s_rxd_reg   <= 2'b00;
      outclk_reg  <= 1'b0;
      out_reg     <= 2'b00;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      crc_chk_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pcnt_reg    <= pcnt_next;
      dcnt_reg    <= dcnt_next;
      s_valid_reg <= s_valid_next;
      s_crsdv_reg <= s_crsdv_next;
      s_rxd_reg   <= s_rxd_next;
      outclk_reg  <= outclk_next;
      out_reg     <= out_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      crc_chk_reg <= crc_chk_next;
    end
  end

  // The CRC absorbs the last emitted dibit on the same edge that raises done.
  rmii_rx_framer_crc32 u_crc32 (
    .clk   (clk),
    .rst   (rst | sfd_accept),
    .inclk (outclk_reg),
    .in    (out_reg),
    .shift (1'b0),
    .out   (crc_out)
  );

  assign outclk = outclk_reg;
  assign out    = out_reg;
  assign done   = done_reg;
  assign err    = err_reg;
  assign crc_ok = done_reg & crc_chk_reg & (crc_out == ~ETH_CRC_RESIDUE);

endmodule

// File: tb/tb_rmii_rx_framer.sv
// Directed bench for rmii_rx_framer: drives RMII frames dibit by dibit and checks the
// emitted body stream and the done/crc_ok/err status against bench-built frames.
module tb_rmii_rx_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic       crsdv;
  logic [1:0] rxd;
  logic       outclk;
  logic [1:0] out;
  logic       done;
  logic       crc_ok;
  logic       err;

  always #10 clk = ~clk;

  rmii_rx_framer dut (
    .clk    (clk),
    .rst    (rst),
    .crsdv  (crsdv),
    .rxd    (rxd),
    .outclk (outclk),
    .out    (out),
    .done   (done),
    .crc_ok (crc_ok),
    .err    (err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  logic [7:0] body [0:1535];
  int exp_dibits = 0;
  int frm_id     = 0;

  function automatic logic [1:0] dib(input int i);
    logic [7:0] b;
    b = body[i / 4];
    return b[2 * (i % 4) +: 2];
  endfunction

  // Output monitor, cleared whenever the stimulus starts a new frame.
  int   seen_id = 0;
  int   mon_cnt, mon_bad, mon_gap, mon_done, mon_late;
  logic mon_crc, mon_err, started, prev_oc;

  always @(negedge clk) begin
    if (frm_id != seen_id) begin
      seen_id  <= frm_id;
      mon_cnt  <= 0;
      mon_bad  <= 0;
      mon_gap  <= 0;
      mon_done <= 0;
      mon_late <= 0;
      mon_crc  <= 1'b0;
      mon_err  <= 1'b0;
      started  <= 1'b0;
    end else begin
      if (outclk) begin
        if (started && !prev_oc) mon_gap <= mon_gap + 1;
        if (mon_cnt >= exp_dibits || out !== dib(mon_cnt)) mon_bad <= mon_bad + 1;
        mon_cnt <= mon_cnt + 1;
        started <= 1'b1;
      end
      if (done) begin
        mon_done <= mon_done + 1;
        mon_crc  <= crc_ok;
        mon_err  <= err;
        if (!prev_oc) mon_late <= mon_late + 1;
      end
    end
    prev_oc <= outclk;
  end

  task automatic drive(input logic c, input logic [1:0] d);
    crsdv = c;
    rxd   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 2'b00);
  endtask

  // n-byte body: deterministic payload followed by a correct little-endian FCS.
  task automatic build(input int n, input int seed);
    logic [31:0] c;
    c = '1;
    for (int i = 0; i < n - 4; i++) begin
      body[i] = 8'(i * 29 + seed);
      c ^= {24'h0, body[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hedb88320) : (c >> 1);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) body[n - 4 + k] = c[8 * k +: 8];
  endtask

  task automatic send(input int pre, input int ndib, input bit tog);
    logic c;
    frm_id++;
    idle(1);
    repeat (pre) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    for (int i = 0; i < ndib; i++) begin
      c = (tog && i >= ndib - 8) ? logic'((i - (ndib - 8)) % 2) : 1'b1;
      drive(c, dib(i));
    end
    idle(6);
  endtask

  // exp_crc < 0 leaves crc_ok unchecked.
  task automatic report(input string name, input int exp_cnt, input int exp_done,
                        input int exp_crc, input int exp_err);
    $display("frame %s: dibits=%0d dones=%0d crc_ok=%0b err=%0b", name, mon_cnt, mon_done,
             mon_crc, mon_err);
    chk({name, ".count"}, mon_cnt, exp_cnt);
    chk({name, ".data"}, mon_bad, 0);
    chk({name, ".gap"}, mon_gap, 0);
    chk({name, ".done"}, mon_done, exp_done);
    if (exp_done > 0) begin
      chk({name, ".done_pos"}, mon_late, 0);
      chk({name, ".err"}, {31'b0, mon_err}, exp_err);
      if (exp_crc >= 0) chk({name, ".crc_ok"}, {31'b0, mon_crc}, exp_crc);
    end
  endtask

  initial begin
    rst   = 1'b1;
    crsdv = 1'b0;
    rxd   = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.outputs", {27'b0, outclk, out, done, crc_ok, err}, 0);
    rst = 1'b0;
    idle(2);

    build(64, 3);
    exp_dibits = 256;
    send(28, 256, 1'b0);
    report("good64", 256, 1, 1, 0);

    body[20] ^= 8'h04;
    send(28, 256, 1'b0);
    report("bitflip", 256, 1, 0, 0);

    build(64, 5);
    send(28, 256, 1'b1);
    report("toggle", 256, 1, 1, 0);

    send(9, 256, 1'b0);
    report("pre9", 256, 1, 1, 0);

    send(8, 256, 1'b0);
    report("pre8", 0, 0, -1, 0);

    body[64] = 8'h00;
    exp_dibits = 257;
    send(28, 257, 1'b0);
    report("misalign", 257, 1, -1, 1);

    build(60, 7);
    exp_dibits = 240;
    send(28, 240, 1'b0);
    report("runt", 240, 1, 1, 1);

    build(1518, 9);
    exp_dibits = 6072;
    send(28, 6072, 1'b0);
    report("max", 6072, 1, 1, 0);

    build(1519, 11);
    exp_dibits = 6072;
    send(28, 6076, 1'b0);
    report("oversize", 6072, 1, 0, 1);

    // false carrier: bad preamble dibit, then SFD-looking data inside the drop
    exp_dibits = 0;
    frm_id++;
    idle(1);
    repeat (3) drive(1'b1, 2'b01);
    drive(1'b1, 2'b10);
    repeat (4) drive(1'b1, 2'b11);
    idle(6);
    report("falsecarrier", 0, 0, -1, 0);

    // reset in the middle of a body
    build(64, 13);
    exp_dibits = 256;
    frm_id++;
    idle(1);
    repeat (28) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    for (int i = 0; i < 100; i++) drive(1'b1, dib(i));
    chk("rst.outclk_before", {31'b0, outclk}, 1);
    rst = 1'b1;
    drive(1'b1, dib(100));
    chk("rst.outclk_after", {31'b0, outclk}, 0);
    chk("rst.done_after", {31'b0, done}, 0);
    rst = 1'b0;
    idle(6);
    report("midreset", 99, 0, -1, 0);

    send(28, 256, 1'b0);
    report("after_reset", 256, 1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
